// File: rtl/line_mem_sequencer.sv
// Burst sequencer between the cache line adapter and the main-memory word bus:
// optional writeback of the adapter's buffered line, then a word-by-word line fill.
module line_mem_sequencer #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int LINE_BITS      = $clog2(WORDS_PER_LINE),
  parameter int BYTE_BITS      = 2
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 fill_req,
  input  logic                 wb_req,
  input  logic [31:0]          fill_addr,
  input  logic [31:0]          wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 busy,
  output logic                 done,
  output logic                 adapter_clr,
  output logic                 adapter_we,
  output logic                 adapter_next,
  output logic [WORD_SIZE-1:0] fill_data,
  output logic [31:0]          mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [1:0]           dbg_state
);

  localparam int OFS_BITS = LINE_BITS + BYTE_BITS;
  localparam logic [LINE_BITS-1:0] LAST_WORD = LINE_BITS'(WORDS_PER_LINE - 1);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFS_BITS) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [LINE_BITS-1:0] word_cnt;
  logic                 fill_pend;
  logic [31:0]          wb_addr_q;
  logic [31:0]          fill_addr_q;
  logic                 start;
  logic                 last_word;
  logic [31:0]          base_addr;

  assign start     = (state == IDLE) && (wb_req || fill_req);
  assign last_word = (word_cnt == LAST_WORD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Memory handshake: mem_re/mem_we act as valid, mem_ack as ready. A request
  // with its address/data is held unchanged until the cycle mem_ack is high;
  // that cycle transfers the word, and the next word is presented after it.
  always_comb begin
    base_addr    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    adapter_clr  = start;
    adapter_we   = 1'b0;
    adapter_next = 1'b0;
    fill_data    = '0;
    case (state)
      WB: begin
        base_addr    = wb_addr_q;
        mem_we       = 1'b1;
        mem_wdata    = wb_data;
        adapter_next = mem_ack;
        // Rewind the adapter for the fill; clr wins over next inside the adapter.
        adapter_clr  = mem_ack && last_word && fill_pend;
      end
      RD: begin
        base_addr    = fill_addr_q;
        mem_re       = 1'b1;
        adapter_we   = mem_ack;
        adapter_next = mem_ack;
        fill_data    = mem_ack ? mem_rdata : '0;
      end
      default: ;
    endcase
    if (mem_re || mem_we)
      mem_addr = (base_addr & LINE_MASK) + (32'(word_cnt) << BYTE_BITS);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      word_cnt    <= '0;
      fill_pend   <= 1'b0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req) begin
            wb_addr_q   <= wb_addr;
            fill_addr_q <= fill_addr;
            fill_pend   <= fill_req;
            word_cnt    <= '0;
            state       <= WB;
          end else if (fill_req) begin
            fill_addr_q <= fill_addr;
            word_cnt    <= '0;
            state       <= RD;
          end
        end
        WB: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + LINE_BITS'(1);
            if (last_word) state <= fill_pend ? RD : DONE;
          end
        end
        RD: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + LINE_BITS'(1);
            if (last_word) state <= DONE;
          end
        end
        DONE: begin
          fill_pend <= 1'b0;
          word_cnt  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_sequencer.sv
// Bench for line_mem_sequencer: directed vector table, reset-mid-burst sequence,
// and randomized operations checked against a transaction-queue model.
module tb_line_mem_sequencer;

  localparam int W   = 32;
  localparam int WPL = 8;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         fill_req, wb_req;
  logic [31:0]  fill_addr, wb_addr;
  logic [W-1:0] wb_data;
  logic         busy, done, adapter_clr, adapter_we, adapter_next;
  logic [W-1:0] fill_data;
  logic [31:0]  mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_re, mem_we;
  logic [W-1:0] mem_rdata;
  logic         mem_ack;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  line_mem_sequencer #(.WORD_SIZE(W), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .clr_n(clr_n), .fill_req(fill_req), .wb_req(wb_req),
    .fill_addr(fill_addr), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .adapter_clr(adapter_clr), .adapter_we(adapter_we),
    .adapter_next(adapter_next), .fill_data(fill_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Expected memory transactions: bit 32 = write, bits 31:0 = word address.
  logic [32:0]  exp_q[$];
  logic [W-1:0] wb_line[WPL];

  typedef struct {
    logic        wb;
    logic        fill;
    logic [31:0] wa;
    logic [31:0] fa;
    int          wait_fix;
    logic        repulse;
    int          exp_cycles;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int next_wait(input int wait_fix);
    return (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
  endfunction

  task automatic run_op(input logic wb, input logic fill, input logic [31:0] wa,
                        input logic [31:0] fa, input int wait_fix, input logic repulse,
                        input int exp_cycles, input logic [31:0] exp_first);
    int          cyc;
    int          wait_left;
    int          n_wr;
    logic [32:0] head;
    logic        ack;
    bit          seen_first;
    bit          finished;
    logic [31:0] wbase;
    logic [31:0] fbase;
    wbase = wa & ~32'(WPL * 4 - 1);
    fbase = fa & ~32'(WPL * 4 - 1);
    exp_q.delete();
    if (wb) for (int i = 0; i < WPL; i++) exp_q.push_back({1'b1, wbase + 32'(i * 4)});
    if (fill) for (int i = 0; i < WPL; i++) exp_q.push_back({1'b0, fbase + 32'(i * 4)});
    for (int i = 0; i < WPL; i++) wb_line[i] = $urandom;

    tick();
    wb_req    = wb;
    fill_req  = fill;
    wb_addr   = wa;
    fill_addr = fa;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    wb_data   = $urandom;
    settle();
    chk("req_busy", busy, 0);
    chk("req_clr", adapter_clr, 1);

    wait_left  = next_wait(wait_fix);
    n_wr       = 0;
    finished   = 0;
    seen_first = 0;
    for (cyc = 1; cyc <= 400 && !finished; cyc++) begin
      tick();
      wb_req    = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
      fill_req  = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_addr   = $urandom;
      fill_addr = $urandom;
      mem_rdata = $urandom;
      wb_data   = wb_line[n_wr % WPL];
      if (exp_q.size() == 0) begin
        mem_ack = 1'($urandom_range(0, 1));
        settle();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_re", mem_re, 0);
        chk("done_we", mem_we, 0);
        if (exp_cycles >= 0) chk("latency", 32'(cyc), 32'(exp_cycles));
        finished = 1;
      end else begin
        head    = exp_q[0];
        ack     = (wait_left == 0);
        mem_ack = ack;
        settle();
        if (!seen_first) begin
          chk("first_addr", mem_addr, exp_first);
          seen_first = 1;
        end
        chk("busy", busy, 1);
        chk("early_done", done, 0);
        chk("mem_we", mem_we, head[32]);
        chk("mem_re", mem_re, !head[32]);
        chk("mem_addr", mem_addr, head[31:0]);
        if (head[32]) chk("mem_wdata", mem_wdata, wb_line[n_wr]);
        chk("adapter_we", adapter_we, ack && !head[32]);
        chk("adapter_next", adapter_next, ack);
        chk("adapter_clr", adapter_clr, ack && head[32] && (exp_q.size() == WPL + 1));
        if (ack && !head[32]) chk("fill_data", fill_data, mem_rdata);
        if (ack) begin
          void'(exp_q.pop_front());
          if (head[32]) n_wr++;
          wait_left = next_wait(wait_fix);
        end else begin
          wait_left--;
        end
      end
    end
    if (!finished) chk("done_timeout", 0, 1);

    tick();
    wb_req   = 1'b0;
    fill_req = 1'b0;
    mem_ack  = 1'($urandom_range(0, 1));
    settle();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_re", mem_re, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_clr", adapter_clr, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0,   32'h0000_1234, 0, 1'b0, 9,  32'h0000_1220};
    vecs[1] = '{1'b1, 1'b0, 32'h40,  32'h0,         2, 1'b0, 25, 32'h0000_0040};
    vecs[2] = '{1'b1, 1'b1, 32'h100, 32'h200,       0, 1'b0, 17, 32'h0000_0100};
    vecs[3] = '{1'b0, 1'b1, 32'h0,   32'h0000_5000, 0, 1'b1, 9,  32'h0000_5000};
    vecs[4] = '{1'b0, 1'b1, 32'h0,   32'hFFFF_FFFC, 0, 1'b0, 9,  32'hFFFF_FFE0};
    vecs[5] = '{1'b1, 1'b0, 32'h7F,  32'h0,         0, 1'b1, 9,  32'h0000_0060};

    clr_n = 1'b0; fill_req = 1'b0; wb_req = 1'b0; fill_addr = '0; wb_addr = '0;
    wb_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_adapter", {adapter_clr, adapter_we, adapter_next}, 0);
    repeat (2) tick();
    clr_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].wb, vecs[v].fill, vecs[v].wa, vecs[v].fa, vecs[v].wait_fix,
             vecs[v].repulse, vecs[v].exp_cycles, vecs[v].exp_first);

    // Reset asserted while the 4th read word is on the bus.
    tick();
    fill_req = 1'b1; fill_addr = 32'h0000_3008; mem_ack = 1'b0;
    settle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      fill_req = 1'b0; mem_ack = 1'b1;
      settle();
    end
    tick();
    mem_ack = 1'b1;
    settle();
    chk("rst_mid_addr", mem_addr, 32'h0000_300C);
    chk("rst_mid_re_pre", mem_re, 1);
    clr_n = 1'b0;
    #1;
    chk("rst_mid_re", mem_re, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", adapter_we, 0);
    chk("rst_mid_next", adapter_next, 0);
    tick();
    clr_n = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ack = 1'($urandom_range(0, 1));
      settle();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
    end
    run_op(1'b0, 1'b1, 32'h0, 32'h0000_3008, 0, 1'b0, 9, 32'h0000_3000);

    for (int r = 0; r < 24; r++) begin
      int          kind;
      logic [31:0] wa;
      logic [31:0] fa;
      kind = int'($urandom_range(0, 2));
      wa   = $urandom;
      fa   = $urandom;
      run_op(kind != 0, kind != 1, wa, fa, -1, 1'b1, -1,
             ((kind != 0) ? wa : fa) & ~32'(WPL * 4 - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
